// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - column-wise fabric configuration sequencer
// Serializes host words LSB-first into one column chain at a time, then pulses cset.
module fpga_config_loader #(
  parameter int MX       = 3,
  parameter int WORD_W   = 32,
  parameter int COL_BITS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic [MX-1:0]     col_cen,
  output logic              shift_out,
  output logic              cset,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int WPC   = (COL_BITS + WORD_W - 1) / WORD_W;
  localparam int COL_W = (MX > 1) ? $clog2(MX) : 1;
  localparam int WC_W  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int REM_W = $clog2(COL_BITS + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MX - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WORD_W - 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(COL_BITS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t             state, state_n;
  logic [COL_W-1:0]   col;
  logic [WC_W-1:0]    wcnt;
  logic [BC_W-1:0]    bcnt;
  logic [WORD_W-1:0]  sreg;
  logic [WORD_W-1:0]  sreg_sh;
  logic [REM_W-1:0]   remaining;
  logic               col_end;
  logic               word_end;
  logic               last_col;

  assign sreg_sh  = sreg >> 1;
  assign col_end  = (remaining == REM_W'(1));
  assign word_end = (bcnt == BC_LAST) || col_end;
  assign last_col = (col == COL_LAST);

  assign word_ready = (state == S_LOAD);
  assign col_cen    = (state == S_SHIFT) ? (MX'(1) << col) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (abort)           state_n = S_IDLE;
        else if (word_valid) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)         state_n = S_IDLE;
        else if (col_end)  state_n = last_col ? S_LATCH : S_LOAD;
        else if (word_end) state_n = S_LOAD;
      end
      S_LATCH: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      sreg      <= '0;
      remaining <= '0;
      shift_out <= 1'b0;
      cset      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      // Outputs are registered off the next state so they switch with col_cen.
      busy      <= (state_n != S_IDLE);
      cset      <= (state_n == S_LATCH);
      shift_out <= 1'b0;
      if (state_n == S_SHIFT)
        shift_out <= (state == S_LOAD) ? word_data[0] : sreg_sh[0];

      case (state)
        S_IDLE: begin
          if (start) begin
            col       <= '0;
            wcnt      <= '0;
            remaining <= REM_FULL;
            done      <= 1'b0;
            aborted   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
          end else if (word_valid) begin
            sreg <= word_data;
            bcnt <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            sreg      <= sreg_sh;
            bcnt      <= bcnt + BC_W'(1);
            remaining <= remaining - REM_W'(1);
            // Leftover high bits of a short final word are simply abandoned here.
            if (col_end) begin
              if (!last_col) begin
                col       <= col + COL_W'(1);
                wcnt      <= '0;
                remaining <= REM_FULL;
              end
            end else if (word_end) begin
              wcnt <= wcnt + WC_W'(1);
            end
          end
        end
        S_LATCH: begin
          if (abort) aborted <= 1'b1;
          else       done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
